// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq -- multi-cycle control sequencer for the ProBotion core.
//
// Each instruction moves through FETCH, DECODE, EXECUTE, an optional MEM and
// WRITEBACK. This block owns the program counter. Instruction and data memory
// are reached through req/ack handshakes that may insert any number of wait
// states. Decoder, ALU and register file are external: they hand in decoded
// flags and receive the strobes produced here.
//
// Parameters
//   PCW      program counter / instruction address width
//   IW       instruction word width
//   DW       data word width
//   BOOT_PC  PC loaded on reset and on start
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                synchronous (re)start, overrides every state
//   done                 high from halt until the next start/rst
//   pc                   current program counter
//   im_req/addr/ack/rdata  instruction fetch handshake
//   instr                latched instruction word
//   dec_do               one-cycle pulse in DECODE
//   ex_jump, jump_on_zero, alu_eq0, mem_rd, mem_wr, rf_wr, signal_done,
//   jump_target          decoded control inputs
//   alu_latch            one-cycle pulse in EXECUTE
//   dm_req/we/ack/rdata  data memory handshake
//   ld_data              load data captured on the data ack
//   rf_we                register file write strobe in WRITEBACK
//   perf_cycles, perf_retired  performance counters
//
// Build option
//   CORE_SEQ_PERF_EN  when defined, the performance counters are built;
//                     otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module core_seq #(
    parameter int             PCW     = 10,
    parameter int             IW      = 9,
    parameter int             DW      = 8,
    parameter logic [PCW-1:0] BOOT_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           done,
    output logic [PCW-1:0] pc,
    output logic           im_req,
    output logic [PCW-1:0] im_addr,
    input  logic           im_ack,
    input  logic [IW-1:0]  im_rdata,
    output logic [IW-1:0]  instr,
    output logic           dec_do,
    input  logic           ex_jump,
    input  logic           jump_on_zero,
    input  logic           alu_eq0,
    input  logic           mem_rd,
    input  logic           mem_wr,
    input  logic           rf_wr,
    input  logic           signal_done,
    input  logic [PCW-1:0] jump_target,
    output logic           alu_latch,
    output logic           dm_req,
    output logic           dm_we,
    input  logic           dm_ack,
    input  logic [DW-1:0]  dm_rdata,
    output logic [DW-1:0]  ld_data,
    output logic           rf_we,
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PCW-1:0] r_pc;
    logic [IW-1:0]  r_instr;
    logic [DW-1:0]  r_ld_data;
    logic           r_taken;
    logic           r_done;
    logic           w_taken;

    assign w_taken = ex_jump & (alu_eq0 == jump_on_zero);

    // State register. Reset forces IDLE asynchronously, so the requests,
    // which decode straight from the state, drop in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode. Acks only matter in the state that
    // raises the matching request, so stale acks elsewhere are harmless.
    always_comb begin
        w_next    = r_state;
        im_req    = 1'b0;
        dec_do    = 1'b0;
        alu_latch = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
            end
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ack) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_do = 1'b1;
                w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_latch = 1'b1;
                w_next    = (mem_rd | mem_wr) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = mem_wr;
                if (dm_ack) begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we  = rf_wr;
                w_next = signal_done ? S_HALT : S_FETCH;
            end
            S_HALT: begin
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (start) begin
            w_next = S_FETCH;
        end
    end

    // Program counter, instruction/load capture, branch decision and done.
    // A load that is also flagged as a store is treated as a store, so
    // ld_data is left alone in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= BOOT_PC;
            r_instr   <= '0;
            r_ld_data <= '0;
            r_taken   <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_pc    <= BOOT_PC;
            r_taken <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (r_state == S_FETCH && im_ack) begin
                r_instr <= im_rdata;
            end
            if (r_state == S_EXECUTE) begin
                r_taken <= w_taken;
            end
            if (r_state == S_MEM && dm_ack && mem_rd && !mem_wr) begin
                r_ld_data <= dm_rdata;
            end
            if (r_state == S_WRITEBACK) begin
                r_pc <= r_taken ? jump_target : r_pc + PCW'(1);
                if (signal_done) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign pc      = r_pc;
    assign im_addr = r_pc;
    assign instr   = r_instr;
    assign ld_data = r_ld_data;
    assign done    = r_done;

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_retired;

    // Busy-cycle and retired-instruction counters; both restart on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles  <= '0;
            r_perf_retired <= '0;
        end else if (start) begin
            r_perf_cycles  <= '0;
            r_perf_retired <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (r_state == S_WRITEBACK) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_retired = r_perf_retired;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// ---------------------------------------------------------------------------
// tb_core_seq -- self-checking bench for core_seq.
//
// Inputs change on the falling clock edge and outputs are observed there,
// away from the active rising edge. Each scenario pushes its predicted
// outcome onto a scoreboard queue when it drives an instruction, and pops
// it when the sequencer has finished that instruction.
// ---------------------------------------------------------------------------
module tb_core_seq;

    localparam int             PCW  = 10;
    localparam int             IW   = 9;
    localparam int             DW   = 8;
    localparam logic [PCW-1:0] BOOT = 10'h000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           done;
    logic [PCW-1:0] pc;
    logic           im_req;
    logic [PCW-1:0] im_addr;
    logic           im_ack;
    logic [IW-1:0]  im_rdata;
    logic [IW-1:0]  instr;
    logic           dec_do;
    logic           ex_jump;
    logic           jump_on_zero;
    logic           alu_eq0;
    logic           mem_rd;
    logic           mem_wr;
    logic           rf_wr;
    logic           signal_done;
    logic [PCW-1:0] jump_target;
    logic           alu_latch;
    logic           dm_req;
    logic           dm_we;
    logic           dm_ack;
    logic [DW-1:0]  dm_rdata;
    logic [DW-1:0]  ld_data;
    logic           rf_we;
    logic [31:0]    perf_cycles;
    logic [31:0]    perf_retired;

    core_seq #(.PCW(PCW), .IW(IW), .DW(DW), .BOOT_PC(BOOT)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .pc(pc),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .instr(instr), .dec_do(dec_do),
        .ex_jump(ex_jump), .jump_on_zero(jump_on_zero), .alu_eq0(alu_eq0),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_wr(rf_wr), .signal_done(signal_done),
        .jump_target(jump_target), .alu_latch(alu_latch),
        .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ld_data(ld_data), .rf_we(rf_we),
        .perf_cycles(perf_cycles), .perf_retired(perf_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           exJump, joz, eq0, rd, wr, rfWr, sDone;
        logic [PCW-1:0] tgt;
        int             wi, wd;
        logic [IW-1:0]  imData;
        logic [DW-1:0]  dmData;
    } instrT;

    typedef struct {
        int             lat, imReqCyc, dmReqCyc, dmWeCyc, decCyc, aluCyc, rfCyc;
        logic [PCW-1:0] addr, pcAfter;
        logic           addrStable, timeout;
        logic [IW-1:0]  instrVal;
        logic [DW-1:0]  ldVal;
    } obsT;

    typedef struct {
        int             lat;
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instrVal;
    } expT;

    expT            sbQ[$];
    int             nVectors = 0;
    int             nMiscompares = 0;
    logic [PCW-1:0] modelPc;

    // Plain non-jumping, non-memory instruction used as a starting point
    function automatic instrT nop();
        instrT d;
        d.exJump = 0; d.joz = 0; d.eq0 = 0; d.rd = 0; d.wr = 0; d.rfWr = 0;
        d.sDone = 0; d.tgt = '0; d.wi = 0; d.wd = 0; d.imData = 9'h000; d.dmData = 8'h00;
        return d;
    endfunction

    // Reference model: next PC and latency of one instruction
    function automatic expT predict(instrT d, logic [PCW-1:0] curPc);
        expT  e;
        logic taken;
        taken      = d.exJump && (d.eq0 == d.joz);
        e.pc       = taken ? d.tgt : curPc + 10'd1;
        e.lat      = 4 + d.wi + ((d.rd || d.wr) ? 1 + d.wd : 0);
        e.instrVal = d.imData;
        return e;
    endfunction

    // Pulse start for one cycle; afterwards the sequencer sits in FETCH
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelPc = BOOT;
    endtask

    // Drive one instruction from its first FETCH cycle to the next FETCH
    // (or to done), answering the handshakes after the requested waits.
    task automatic runInstr(input instrT d, output obsT o);
        int   cyc;
        logic sawDec;
        logic fin;
        ex_jump = d.exJump; jump_on_zero = d.joz; alu_eq0 = d.eq0;
        mem_rd = d.rd; mem_wr = d.wr; rf_wr = d.rfWr; signal_done = d.sDone;
        jump_target = d.tgt;
        o.lat = 0; o.imReqCyc = 0; o.dmReqCyc = 0; o.dmWeCyc = 0;
        o.decCyc = 0; o.aluCyc = 0; o.rfCyc = 0; o.addr = '0; o.pcAfter = '0;
        o.addrStable = 1'b1; o.timeout = 1'b1; o.instrVal = '0; o.ldVal = '0;
        cyc = 1; sawDec = 0; fin = 0;
        while (cyc < 60 && !fin) begin
            if (im_req) begin
                o.imReqCyc++;
                if (o.imReqCyc == 1) o.addr = im_addr;
                else if (im_addr !== o.addr) o.addrStable = 1'b0;
                im_ack   = (o.imReqCyc > d.wi);
                im_rdata = im_ack ? d.imData : ~d.imData;
            end else begin
                im_ack = 1'b0;
            end
            if (dec_do) begin
                sawDec = 1'b1;
                o.decCyc = cyc;
                o.instrVal = instr;
            end
            if (alu_latch) o.aluCyc = cyc;
            if (rf_we) o.rfCyc = cyc;
            if (dm_req) begin
                o.dmReqCyc++;
                if (dm_we) o.dmWeCyc++;
                dm_ack   = (o.dmReqCyc > d.wd);
                dm_rdata = dm_ack ? d.dmData : ~d.dmData;
            end else begin
                dm_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (sawDec && (im_req || done)) begin
                fin = 1'b1;
                o.timeout = 1'b0;
                o.lat = cyc - 1;
                o.pcAfter = pc;
                o.ldVal = ld_data;
            end
        end
    endtask

    // Outputs held at their reset values while rst is high and afterwards
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; im_ack = 0; dm_ack = 0; im_rdata = '0; dm_rdata = '0;
        ex_jump = 0; jump_on_zero = 0; alu_eq0 = 0; mem_rd = 0; mem_wr = 0;
        rf_wr = 0; signal_done = 0; jump_target = '0;
        repeat (2) @(negedge clk);
        nVectors++; if (pc !== BOOT) begin nMiscompares++; $display("[TB] FAIL reset_pc: got %h want %h", pc, BOOT); end
        nVectors++; if ({done, im_req, dm_req, dm_we, dec_do, alu_latch, rf_we} !== 7'b0) begin
            nMiscompares++; $display("[TB] FAIL reset_strobes: got %b want 0000000", {done, im_req, dm_req, dm_we, dec_do, alu_latch, rf_we}); end
        nVectors++; if (instr !== 9'h000 || ld_data !== 8'h00) begin
            nMiscompares++; $display("[TB] FAIL reset_data: got instr=%h ld=%h want 0/0", instr, ld_data); end
        nVectors++; if (perf_cycles !== 32'd0 || perf_retired !== 32'd0) begin
            nMiscompares++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_cycles, perf_retired); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nVectors++; if (im_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL idle_no_fetch: got im_req=%b want 0", im_req); end
    endtask

    // First instruction after start: strobe timing and PC increment
    task automatic test_basic();
        instrT d; obsT o; expT e;
        applyStimulus();
        d = nop(); d.rfWr = 1; d.imData = 9'h1A3;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.addr !== BOOT) begin nMiscompares++; $display("[TB] FAIL basic_addr: got %h want %h", o.addr, BOOT); end
        nVectors++; if (o.decCyc != 2 || o.aluCyc != 3 || o.rfCyc != 4) begin
            nMiscompares++; $display("[TB] FAIL basic_pulses: got %0d/%0d/%0d want 2/3/4", o.decCyc, o.aluCyc, o.rfCyc); end
        nVectors++; if (o.timeout || o.lat != e.lat) begin nMiscompares++; $display("[TB] FAIL basic_latency: got %0d (timeout=%b) want %0d", o.lat, o.timeout, e.lat); end
        nVectors++; if (im_addr !== e.pc) begin nMiscompares++; $display("[TB] FAIL basic_next_addr: got %h want %h", im_addr, e.pc); end
        modelPc = e.pc;
    endtask

    // Conditional jump taken and not taken; rf_we must stay low with rf_wr=0
    task automatic test_branch();
        instrT d; obsT o; expT e;
        for (int i = 0; i < 2; i++) begin
            d = nop(); d.exJump = 1; d.joz = 1; d.eq0 = (i == 0); d.tgt = 10'h2A5;
            sbQ.push_back(predict(d, modelPc));
            runInstr(d, o);
            e = sbQ.pop_front();
            nVectors++; if (o.timeout || o.pcAfter !== e.pc) begin
                nMiscompares++; $display("[TB] FAIL branch_pc%0d: got %h want %h", i, o.pcAfter, e.pc); end
            nVectors++; if (o.rfCyc != 0) begin nMiscompares++; $display("[TB] FAIL branch_rfwe%0d: got pulse at %0d want none", i, o.rfCyc); end
            modelPc = e.pc;
        end
    endtask

    // Instruction fetch with three wait states
    task automatic test_back_to_back_wait();
        instrT d; obsT o; expT e;
        d = nop(); d.wi = 3; d.imData = 9'h0F0;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.imReqCyc != 4 || !o.addrStable) begin
            nMiscompares++; $display("[TB] FAIL wait_req: got %0d cycles stable=%b want 4 stable=1", o.imReqCyc, o.addrStable); end
        nVectors++; if (o.instrVal !== e.instrVal) begin nMiscompares++; $display("[TB] FAIL wait_instr: got %h want %h", o.instrVal, e.instrVal); end
        nVectors++; if (o.timeout || o.lat != e.lat || o.pcAfter !== e.pc) begin
            nMiscompares++; $display("[TB] FAIL wait_lat: got %0d pc=%h want %0d pc=%h", o.lat, o.pcAfter, e.lat, e.pc); end
        modelPc = e.pc;
    endtask

    // Store with two waits, load, then rd+wr together behaving as a store
    task automatic test_mem();
        instrT d; obsT o; expT e;
        d = nop(); d.wr = 1; d.wd = 2;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.dmReqCyc != 3 || o.dmWeCyc != 3) begin
            nMiscompares++; $display("[TB] FAIL store_req: got req=%0d we=%0d want 3/3", o.dmReqCyc, o.dmWeCyc); end
        nVectors++; if (o.timeout || o.lat != e.lat || o.pcAfter !== e.pc) begin
            nMiscompares++; $display("[TB] FAIL store_lat: got %0d pc=%h want %0d pc=%h", o.lat, o.pcAfter, e.lat, e.pc); end
        modelPc = e.pc;
        d = nop(); d.rd = 1; d.wd = 1; d.dmData = 8'h5C;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.ldVal !== 8'h5C || o.dmWeCyc != 0) begin
            nMiscompares++; $display("[TB] FAIL load_data: got %h we=%0d want 5c we=0", o.ldVal, o.dmWeCyc); end
        nVectors++; if (o.timeout || o.lat != e.lat) begin nMiscompares++; $display("[TB] FAIL load_lat: got %0d want %0d", o.lat, e.lat); end
        modelPc = e.pc;
        d = nop(); d.rd = 1; d.wr = 1; d.dmData = 8'h11;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.dmWeCyc != 1 || o.dmReqCyc != 1 || o.ldVal !== 8'h5C) begin
            nMiscompares++; $display("[TB] FAIL rdwr_store: got we=%0d req=%0d ld=%h want 1/1/5c", o.dmWeCyc, o.dmReqCyc, o.ldVal); end
        modelPc = e.pc;
    endtask

    // PC wraps from all-ones to zero
    task automatic test_wrap();
        instrT d; obsT o; expT e;
        d = nop(); d.exJump = 1; d.tgt = 10'h3FF;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        modelPc = e.pc;
        d = nop();
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.timeout || o.pcAfter !== e.pc) begin nMiscompares++; $display("[TB] FAIL wrap_pc: got %h want %h", o.pcAfter, e.pc); end
        modelPc = e.pc;
    endtask

    // signal_done halts with done held; start restarts from BOOT
    task automatic test_halt();
        instrT d; obsT o; expT e;
        d = nop(); d.sDone = 1;
        sbQ.push_back(predict(d, modelPc));
        runInstr(d, o);
        e = sbQ.pop_front();
        nVectors++; if (o.timeout || done !== 1'b1 || o.pcAfter !== e.pc) begin
            nMiscompares++; $display("[TB] FAIL halt_done: got done=%b pc=%h want 1 pc=%h", done, o.pcAfter, e.pc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nVectors++; if (done !== 1'b1 || im_req !== 1'b0) begin
                nMiscompares++; $display("[TB] FAIL halt_hold: got done=%b im_req=%b want 1/0", done, im_req); end
        end
        applyStimulus();
        nVectors++; if (done !== 1'b0 || im_req !== 1'b1 || im_addr !== BOOT) begin
            nMiscompares++; $display("[TB] FAIL restart: got done=%b req=%b addr=%h want 0/1/%h", done, im_req, im_addr, BOOT); end
    endtask

    // Counters after three zero-wait instructions (zero when not built)
    task automatic test_perf();
        instrT d; obsT o; expT e;
        logic [31:0] wantCycles, wantRetired;
`ifdef CORE_SEQ_PERF_EN
        wantCycles = 32'd12; wantRetired = 32'd3;
`else
        wantCycles = 32'd0; wantRetired = 32'd0;
`endif
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            d = nop(); d.sDone = (i == 2);
            sbQ.push_back(predict(d, modelPc));
            runInstr(d, o);
            e = sbQ.pop_front();
            nVectors++; if (o.timeout || o.pcAfter !== e.pc) begin
                nMiscompares++; $display("[TB] FAIL perf_pc%0d: got %h want %h", i, o.pcAfter, e.pc); end
            modelPc = e.pc;
        end
        @(negedge clk);
        nVectors++; if (perf_cycles !== wantCycles || perf_retired !== wantRetired) begin
            nMiscompares++; $display("[TB] FAIL perf_counts: got %0d/%0d want %0d/%0d", perf_cycles, perf_retired, wantCycles, wantRetired); end
    endtask

    // Reset during MEM, then stale acks: everything stays at reset values
    task automatic test_rst_mem();
        int guard;
        applyStimulus();
        ex_jump = 0; mem_rd = 1; mem_wr = 0; rf_wr = 0; signal_done = 0;
        im_ack = 1'b1; im_rdata = 9'h1FF; dm_ack = 1'b0; dm_rdata = 8'hEE;
        guard = 0;
        while (!dm_req && guard < 10) begin
            @(negedge clk);
            if (!im_req) im_ack = 1'b0;
            guard++;
        end
        nVectors++; if (dm_req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rst_reach_mem: got dm_req=%b want 1", dm_req); end
        #2 rst = 1'b1;
        #1;
        nVectors++; if (dm_req !== 1'b0 || im_req !== 1'b0) begin
            nMiscompares++; $display("[TB] FAIL rst_drop_req: got dm=%b im=%b want 0/0", dm_req, im_req); end
        @(negedge clk);
        rst = 1'b0; dm_ack = 1'b1; im_ack = 1'b1;
        repeat (3) @(negedge clk);
        nVectors++; if ({done, im_req, dm_req, dec_do, alu_latch, rf_we} !== 6'b0 || pc !== BOOT) begin
            nMiscompares++; $display("[TB] FAIL rst_stale_ack: got strobes=%b pc=%h want 000000 pc=%h",
                                     {done, im_req, dm_req, dec_do, alu_latch, rf_we}, pc, BOOT); end
        nVectors++; if (instr !== 9'h000 || ld_data !== 8'h00 || perf_cycles !== 32'd0) begin
            nMiscompares++; $display("[TB] FAIL rst_data: got instr=%h ld=%h cyc=%0d want 0/0/0", instr, ld_data, perf_cycles); end
        dm_ack = 1'b0; im_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_back_to_back_wait();
        test_mem();
        test_wrap();
        test_halt();
        test_perf();
        test_rst_mem();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/core_seq.md
# core_seq

Parametrised multi-cycle control sequencer for the ProBotion core. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WRITEBACK, and owns the program counter. Instruction and data memory are reached through req/ack handshakes with arbitrary wait states. Decoder, ALU and register file sit outside; they supply decoded control flags and take this block's strobes.

## Interface
- `PCW`, 10: program counter / instruction address width.
- `IW`, 9: instruction word width.
- `DW`, 8: data word width.
- `BOOT_PC`, 0: PC loaded on reset and on `start`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: synchronous (re)start; priority over every state.
- `done` out 1: high from halt until next `start`/`rst`.
- `pc` out PCW: current PC.
- `im_req` out 1, `im_addr` out PCW, `im_ack` in 1, `im_rdata` in IW: instruction fetch handshake.
- `instr` out IW: latched instruction, valid from DECODE onward.
- `dec_do` out 1: one-cycle pulse in DECODE.
- `ex_jump`, `jump_on_zero`, `alu_eq0`, `mem_rd`, `mem_wr`, `rf_wr`, `signal_done` in 1 each: decoded flags, stable from EXECUTE through WRITEBACK.
- `jump_target` in PCW: branch destination.
- `alu_latch` out 1: one-cycle pulse in EXECUTE; datapath captures ALU result.
- `dm_req` out 1, `dm_we` out 1, `dm_ack` in 1, `dm_rdata` in DW: data memory handshake. Address and write data are driven by the datapath.
- `ld_data` out DW: `dm_rdata` captured on load ack.
- `rf_we` out 1: one-cycle pulse in WRITEBACK.
- `perf_cycles` out 32, `perf_retired` out 32: see Configuration.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Transitions:
  - IDLE→FETCH on `start`.
  - FETCH→DECODE on `im_ack`.
  - DECODE→EXECUTE always.
  - EXECUTE→MEM if `mem_rd|mem_wr`, else →WRITEBACK.
  - MEM→WRITEBACK on `dm_ack`.
  - WRITEBACK→HALT if `signal_done`, else →FETCH.
  - HALT holds until `start`.
- `start` in any state: PC←`BOOT_PC`, `done`←0, any pending request dropped, next state FETCH.
- FETCH:
  - `im_req`=1 and `im_addr`=`pc`, held stable until the ack edge.
  - `instr`←`im_rdata` on the ack edge.
- EXECUTE: branch taken = `ex_jump & (alu_eq0 == jump_on_zero)`, registered for WRITEBACK.
- MEM:
  - `dm_req`=1; `dm_we`=`mem_wr` held for the whole request.
  - On ack with `mem_rd`, `ld_data`←`dm_rdata`.
  - `mem_rd` and `mem_wr` both high: treated as a write.
- WRITEBACK:
  - `rf_we`=`rf_wr`.
  - PC←`jump_target` if taken, else PC+1, modulo 2^PCW (all-ones wraps to 0).
  - `signal_done` still updates PC, then enters HALT with `done`=1.
- Ack handling: `im_ack`/`dm_ack` are ignored when the matching `req` is low, including stale acks after `start`/`rst`.

## Timing
- Reset values (asynchronous):
  - state IDLE, `pc`=`BOOT_PC`.
  - `instr`, `ld_data` = 0.
  - all strobes, requests and `done` = 0.
  - perf counters = 0.
- Acks are sampled at the rising edge while `req`=1. An ack in the first request cycle gives zero wait states.
- Instruction latency = 4 + Wi cycles without memory access, 5 + Wi + Wd with one.
  - Wi: cycles `im_ack` is low while `im_req` is high.
  - Wd: cycles `dm_ack` is low while `dm_req` is high.
- `done` rises the cycle after the WRITEBACK in which `signal_done` is high.
- `rst` mid-handshake drops `im_req`/`dm_req` immediately, with no further effect.

## Configuration
- `CORE_SEQ_PERF_EN` defined:
  - `perf_cycles` increments every cycle outside IDLE/HALT.
  - `perf_retired` increments every WRITEBACK.
  - Both clear on `rst`/`start` and wrap at 2^32.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset, `start`, `im_ack` tied 1, non-jump instruction with `rf_wr`=1 → `im_addr`=0; `dec_do`, `alu_latch`, `rf_we` pulse on cycles 2, 3, 4; next `im_addr`=1.
- `ex_jump`=1, `jump_on_zero`=1, `alu_eq0`=1, `jump_target`=0x2A5 → `pc`=0x2A5; repeat with `alu_eq0`=0 → `pc`=old+1.
- `im_ack` delayed 3 cycles → `im_req` high 4 cycles, `im_addr` stable; `instr` equals `im_rdata` from the ack cycle.
- Store with `dm_ack` after 2 cycles → `dm_req`=`dm_we`=1 for 3 cycles. Load, `dm_rdata`=0x5C → `ld_data`=0x5C.
- `pc`=0x3FF, no jump → `pc`=0x000. `signal_done` → `done`=1 held; `start` clears it and fetches from `BOOT_PC`.
- `rst` during MEM, then a late `dm_ack` → all outputs at reset values, no state change. With `CORE_SEQ_PERF_EN`, 3 zero-wait instructions → `perf_cycles`=12, `perf_retired`=3.
